// File: rtl/sub_bytes_unit.sv
// Iterative AES SubBytes / InvSubBytes engine: substitutes a DATA_W-bit state
// LANES bytes per cycle with valid/ready handshakes on both sides.
module sub_bytes_unit #(
    parameter int DATA_W = 128,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inv_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);
    localparam int NBYTES = DATA_W / 8;
    localparam int BEATS  = NBYTES / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((DATA_W % 8) != 0 || LANES < 1 || (NBYTES % LANES) != 0) begin : g_param_check
        $error("sub_bytes_unit: DATA_W must be a multiple of 8 and DATA_W/8 divisible by LANES");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   beat;
    logic [DATA_W-1:0]  work, work_next;
    logic               mode;
    logic               beat_last;
    logic [7:0]         lane_in  [LANES];
    logic [7:0]         lane_out [LANES];

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Lane l handles byte beat*LANES+l; byte 0 sits in the MSBs.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l]  = work[DATA_W-1-8*(int'(beat)*LANES+l) -: 8];
        assign lane_out[l] = mode ? inv_sbox(lane_in[l]) : fwd_sbox(lane_in[l]);
    end

    always_comb begin
        work_next = work;
        for (int l = 0; l < LANES; l++) begin
            work_next[DATA_W-1-8*(int'(beat)*LANES+l) -: 8] = lane_out[l];
        end
    end

    assign beat_last = (beat == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (beat_last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
            work <= '0;
            mode <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            beat <= '0;
            work <= in_data;
            mode <= inv_mode;
        end else if (state == BUSY) begin
            beat <= beat + 1'b1;
            work <= work_next;
        end
    end

    assign out_data = work;

endmodule
